// File: rtl/mem_pkg.sv
// Shared types for the data memory load/store unit.
package mem_pkg;

    // Access size encoding carried on req_size
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_RSVD = 2'd3
    } mem_size_e;

    // Request sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Latency counter width; holds LATENCY-1 for LATENCY up to 8
    localparam int unsigned LSU_CNT_W = 3;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the request interface and a full memory word.
// Store side places right-justified data onto the addressed lanes; load side
// pulls the addressed bytes down to bit 0 and extends them.
module mem_lane_align import mem_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned BYTES = DATA_WIDTH / 8,
    localparam int unsigned OFF_W = $clog2(BYTES)
) (
    input  mem_size_e             st_size,
    input  logic [OFF_W-1:0]      st_offset,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic [BYTES-1:0]      st_be,
    output logic [DATA_WIDTH-1:0] st_wlane,
    input  logic [DATA_WIDTH-1:0] ld_word,
    input  mem_size_e             ld_size,
    input  logic [OFF_W-1:0]      ld_offset,
    input  logic                  ld_unsigned,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [BYTES-1:0]      be_base;
    logic [DATA_WIDTH-1:0] ld_shifted;
    logic [DATA_WIDTH-1:0] ld_mask;
    logic                  ld_fill;

    // Store path: enables for the selected lanes, data moved up to those lanes
    always_comb begin
        be_base = '0;
        unique case (st_size)
            MEM_BYTE: be_base = BYTES'(1);
            MEM_HALF: be_base = BYTES'(3);
            MEM_WORD: be_base = '1;
            default:  be_base = '0;
        endcase
        st_be    = be_base << st_offset;
        st_wlane = st_wdata << {st_offset, 3'b000};
    end

    // Load path: shift selected bytes to bit 0, then mask and fill the upper part
    always_comb begin
        ld_shifted = ld_word >> {ld_offset, 3'b000};
        ld_mask    = '0;
        ld_fill    = 1'b0;
        unique case (ld_size)
            MEM_BYTE: begin
                ld_mask = DATA_WIDTH'(8'hFF);
                ld_fill = ~ld_unsigned & ld_shifted[7];
            end
            MEM_HALF: begin
                ld_mask = DATA_WIDTH'(16'hFFFF);
                ld_fill = ~ld_unsigned & ld_shifted[15];
            end
            MEM_WORD: begin
                ld_mask = '1;
                ld_fill = 1'b0;
            end
            default: begin
                ld_mask = '0;
                ld_fill = 1'b0;
            end
        endcase
        // Mask form keeps this legal when DATA_WIDTH equals the half width
        ld_data = (ld_shifted & ld_mask) | (ld_fill ? ~ld_mask : '0);
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed data RAM with a valid/ready request port, byte/half/word
// accesses, load extension, error reporting and a fixed access latency.
// One request is in flight at a time.
module data_mem_lsu import mem_pkg::*; #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    lsu_state_e            state_q;
    logic [LSU_CNT_W-1:0]  cnt_q;
    logic                  write_q;
    logic                  unsigned_q;
    logic                  err_q;
    mem_size_e             size_q;
    logic [OFF_W-1:0]      offset_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    mem_size_e             req_size_e;
    logic [OFF_W-1:0]      req_offset;
    logic [IDX_W-1:0]      req_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  req_err;
    logic                  accept;
    logic                  store_en;
    logic [BYTES-1:0]      st_be;
    logic [DATA_WIDTH-1:0] st_wlane;
    logic [DATA_WIDTH-1:0] ld_data;

    assign req_size_e = mem_size_e'(req_size);
    assign req_offset = req_addr[OFF_W-1:0];
    assign req_idx    = req_addr[OFF_W +: IDX_W];

    // Ready only in IDLE, and held low for the whole time reset is asserted
    assign req_ready = (state_q == IDLE) & ~rst;
    assign accept    = req_valid & req_ready;

    // Request error classification, evaluated on the live request at accept
    always_comb begin
        misaligned = 1'b0;
        unique case (req_size_e)
            MEM_HALF: misaligned = req_offset[0];
            MEM_WORD: misaligned = |req_offset;
            default:  misaligned = 1'b0;
        endcase
        // Any address bit above the index field means word index >= DEPTH
        out_of_range = (req_addr >> (OFF_W + IDX_W)) != '0;
        req_err      = misaligned | out_of_range | (req_size_e == MEM_RSVD);
        store_en     = accept & req_write & ~req_err;
    end

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .st_size     (req_size_e),
        .st_offset   (req_offset),
        .st_wdata    (req_wdata),
        .st_be       (st_be),
        .st_wlane    (st_wlane),
        .ld_word     (word_q),
        .ld_size     (size_q),
        .ld_offset   (offset_q),
        .ld_unsigned (unsigned_q),
        .ld_data     (ld_data)
    );

    // Array write on the accept edge; contents deliberately have no reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(BYTES); b++) begin
            if (store_en && st_be[b]) begin
                mem_q[req_idx][8*b +: 8] <= st_wlane[8*b +: 8];
            end
        end
    end

    // Request sequencing, latency counting and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= MEM_BYTE;
            offset_q    <= '0;
            word_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        err_q      <= req_err;
                        size_q     <= req_size_e;
                        offset_q   <= req_offset;
                        word_q     <= mem_q[req_idx];
                        cnt_q      <= LSU_CNT_W'(LATENCY - 1);
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_rdata_q <= (err_q || write_q) ? '0 : ld_data;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
